// File: rtl/accelerator_pkg.sv
// Shared types for the PE writeback path: FSM state encoding, widening
// encodings (common with the PE) and the destination element-width helper.
package accelerator_pkg;

  typedef enum logic [1:0] {
    PE_WB_IDLE    = 2'd0,
    PE_WB_COLLECT = 2'd1,
    PE_WB_WRITE   = 2'd2,
    PE_WB_DONE    = 2'd3
  } pe_wb_state_t;

  localparam logic [1:0] WIDEN_NONE = 2'd0;
  localparam logic [1:0] WIDEN_X2   = 2'd1;
  localparam logic [1:0] WIDEN_X4   = 2'd2;

  // log2 of destination element bytes, saturated at 32-bit elements.
  function automatic logic [1:0] eew_log(input logic [1:0] vsew, input logic [1:0] widening);
    logic [2:0] sum;
    sum = {1'b0, vsew} + ((widening == WIDEN_X2) ? 3'd1 :
                          (widening == WIDEN_X4) ? 3'd2 : 3'd0);
    return (sum > 3'd2) ? 2'd2 : sum[1:0];
  endfunction

endpackage

// File: rtl/wb_lane_gen.sv
// Lane decoder: maps a lane index and element width to the byte enables,
// the element bit mask and the left-shift that places the element in its word.
module wb_lane_gen
  import accelerator_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_eew_log,
  output logic [3:0]  o_be,
  output logic [31:0] o_mask,
  output logic [4:0]  o_shift
);

  logic [1:0] w_byte_off;

  // lane < elements-per-word, so the byte offset always fits in two bits
  assign w_byte_off = i_lane << i_eew_log;
  assign o_shift    = {w_byte_off, 3'b000};

  always_comb begin
    o_be   = 4'h0;
    o_mask = 32'h0;
    case (i_eew_log)
      2'd0: begin
        o_be   = 4'b0001 << w_byte_off;
        o_mask = 32'h0000_00FF;
      end
      2'd1: begin
        o_be   = 4'b0011 << w_byte_off;
        o_mask = 32'h0000_FFFF;
      end
      default: begin
        o_be   = 4'b1111;
        o_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

endmodule

// File: rtl/pe_wb_packer.sv
// PE writeback packer: packs a stream of EEW-sized results into byte-enabled
// 32-bit VRF writes. Optional per-element masking under PE_WB_MASK_EN.
module pe_wb_packer
  import accelerator_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int VL_W   = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_vd_addr,
  input  logic [VL_W-1:0]   cfg_vl,
  input  logic [1:0]        cfg_vsew,
  input  logic [1:0]        cfg_widening,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
`ifdef PE_WB_MASK_EN
  input  logic              in_mask,
`endif
  output logic              vrf_wr_en,
  input  logic              vrf_wr_ready,
  output logic [ADDR_W-1:0] vrf_wr_addr,
  output logic [31:0]       vrf_wr_data,
  output logic [3:0]        vrf_wr_be,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshakes: an element moves when in_valid && in_ready at a rising edge;
  // a word is written when vrf_wr_en && vrf_wr_ready at a rising edge, and
  // addr/data/be are held unchanged while vrf_wr_en waits for vrf_wr_ready.

  pe_wb_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [VL_W-1:0]   r_vl;
  logic [VL_W-1:0]   r_cnt;
  logic [1:0]        r_eew;
  logic [1:0]        r_lane;
  logic [31:0]       r_buf;
  logic [3:0]        r_be;

  logic [3:0]        w_lane_be;
  logic [31:0]       w_lane_mask;
  logic [4:0]        w_shift;
  logic [1:0]        w_lane_last;
  logic [VL_W-1:0]   w_cnt_next;
  logic              w_elem_on;
  logic [31:0]       w_elem;

  wb_lane_gen u_lane_gen (
    .i_lane    (r_lane),
    .i_eew_log (r_eew),
    .o_be      (w_lane_be),
    .o_mask    (w_lane_mask),
    .o_shift   (w_shift)
  );

`ifdef PE_WB_MASK_EN
  assign w_elem_on = in_mask;
`else
  assign w_elem_on = 1'b1;
`endif

  assign w_lane_last = (r_eew == 2'd0) ? 2'd3 : (r_eew == 2'd1) ? 2'd1 : 2'd0;
  assign w_cnt_next  = r_cnt + 1'b1;
  // masked-off elements leave their bytes zero as well as disabled
  assign w_elem      = w_elem_on ? ((in_data & w_lane_mask) << w_shift) : 32'h0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= PE_WB_IDLE;
      r_addr  <= '0;
      r_vl    <= '0;
      r_cnt   <= '0;
      r_eew   <= 2'd0;
      r_lane  <= 2'd0;
      r_buf   <= 32'h0;
      r_be    <= 4'h0;
    end else begin
      case (r_state)
        PE_WB_IDLE: begin
          if (start) begin
            r_addr  <= cfg_vd_addr;
            r_vl    <= cfg_vl;
            r_eew   <= eew_log(cfg_vsew, cfg_widening);
            r_cnt   <= '0;
            r_lane  <= 2'd0;
            r_buf   <= 32'h0;
            r_be    <= 4'h0;
            r_state <= (cfg_vl == '0) ? PE_WB_DONE : PE_WB_COLLECT;
          end
        end
        PE_WB_COLLECT: begin
          if (in_valid) begin
            r_buf <= r_buf | w_elem;
            r_be  <= r_be | (w_elem_on ? w_lane_be : 4'h0);
            r_cnt <= w_cnt_next;
            if (r_lane == w_lane_last || w_cnt_next == r_vl) begin
              r_state <= PE_WB_WRITE;
            end else begin
              r_lane <= r_lane + 2'd1;
            end
          end
        end
        PE_WB_WRITE: begin
          if (vrf_wr_ready) begin
            r_addr  <= r_addr + 1'b1;
            r_buf   <= 32'h0;
            r_be    <= 4'h0;
            r_lane  <= 2'd0;
            r_state <= (r_cnt == r_vl) ? PE_WB_DONE : PE_WB_COLLECT;
          end
        end
        default: begin
          r_state <= PE_WB_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == PE_WB_COLLECT);
  assign vrf_wr_en   = (r_state == PE_WB_WRITE);
  assign vrf_wr_addr = r_addr;
  assign vrf_wr_data = r_buf;
  assign vrf_wr_be   = r_be;
  assign busy        = (r_state != PE_WB_IDLE);
  assign done        = (r_state == PE_WB_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pe_wb_packer.sv
// Self-checking bench for pe_wb_packer: an independent packing model fills a
// scoreboard queue; a negedge monitor checks writes, stalls and done timing.
module tb_pe_wb_packer;

  localparam int ADDR_W = 9;
  localparam int VL_W   = 8;
  localparam int W      = ADDR_W + 4 + 32;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              start;
  logic [ADDR_W-1:0] cfg_vd_addr;
  logic [VL_W-1:0]   cfg_vl;
  logic [1:0]        cfg_vsew;
  logic [1:0]        cfg_widening;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_mask;
  logic              vrf_wr_en;
  logic              vrf_wr_ready;
  logic [ADDR_W-1:0] vrf_wr_addr;
  logic [31:0]       vrf_wr_data;
  logic [3:0]        vrf_wr_be;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  pe_wb_packer #(.ADDR_W(ADDR_W), .VL_W(VL_W)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .start        (start),
    .cfg_vd_addr  (cfg_vd_addr),
    .cfg_vl       (cfg_vl),
    .cfg_vsew     (cfg_vsew),
    .cfg_widening (cfg_widening),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
`ifdef PE_WB_MASK_EN
    .in_mask      (in_mask),
`endif
    .vrf_wr_en    (vrf_wr_en),
    .vrf_wr_ready (vrf_wr_ready),
    .vrf_wr_addr  (vrf_wr_addr),
    .vrf_wr_data  (vrf_wr_data),
    .vrf_wr_be    (vrf_wr_be),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  d_arr[256];
  logic         m_arr[256];

  int rdy_mode   = 0;   // 0 always ready, 1 random, 2 stall 3 cycles per write, 3 never
  int stall_left = 3;
  int n_writes   = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int hs_cyc     = 0;

  logic              prev_stall = 1'b0;
  logic [W-1:0]      prev_word;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- VRF ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: vrf_wr_ready = 1'b1;
      1: vrf_wr_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (vrf_wr_en && stall_left > 0) begin
          vrf_wr_ready = 1'b0;
          stall_left--;
        end else begin
          vrf_wr_ready = 1'b1;
          if (vrf_wr_en) stall_left = 3;
        end
      end
      default: vrf_wr_ready = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] cur;
    cur = {vrf_wr_addr, vrf_wr_be, vrf_wr_data};
    if (!n_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_wr_en", vrf_wr_en, 1'b1);
        check("stall_word", cur, prev_word);
      end
      if (vrf_wr_en) check("wr_in_ready", in_ready, 1'b0);
      if (vrf_wr_en && vrf_wr_ready) begin
        n_writes++;
        hs_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_wr", cur, '0);
        else check("wr_word", cur, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = vrf_wr_en && !vrf_wr_ready;
      prev_word  = cur;
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_eew(input int vsew, input int wid);
    int e;
    e = vsew + ((wid == 1) ? 1 : (wid == 2) ? 2 : 0);
    return (e > 2) ? 2 : e;
  endfunction

  function automatic logic elem_on(input int k);
`ifdef PE_WB_MASK_EN
    return m_arr[k];
`else
    return 1'b1;
`endif
  endfunction

  function automatic int push_expected(input int vd, input int vl, input int eew);
    int epw, bits, nw, k;
    logic [63:0] msk;
    logic [31:0] wd;
    logic [3:0]  be;
    epw = 4 >> eew;
    bits = 8 << eew;
    nw = (vl + epw - 1) / epw;
    msk = (64'd1 << bits) - 64'd1;
    for (int w = 0; w < nw; w++) begin
      wd = 32'h0;
      be = 4'h0;
      for (int j = 0; j < epw; j++) begin
        k = w * epw + j;
        if (k < vl && elem_on(k)) begin
          wd = wd | 32'((64'(d_arr[k]) & msk) << (j * bits));
          be = be | 4'(((1 << (1 << eew)) - 1) << (j << eew));
        end
      end
      exp_q.push_back({ADDR_W'(vd + w), be, wd});
    end
    return nw;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input string tag, input int vd, input int vl, input int vsew,
                        input int wid, input int mode, input bit gaps);
    int nw, w0, d0, s_cyc, k, guard;
    bit mid_start, acc;
    rdy_mode   = mode;
    stall_left = 3;
    nw = push_expected(vd, vl, model_eew(vsew, wid));
    w0 = n_writes;
    d0 = done_cnt;
    @(posedge clk); #1;
    start        = 1'b1;
    cfg_vd_addr  = ADDR_W'(vd);
    cfg_vl       = VL_W'(vl);
    cfg_vsew     = 2'(vsew);
    cfg_widening = 2'(wid);
    s_cyc = cyc;
    @(posedge clk); #1;
    start        = 1'b0;
    // scramble config mid-op; it must not matter
    cfg_vd_addr  = ADDR_W'($urandom);
    cfg_vl       = VL_W'($urandom_range(1, 255));
    cfg_vsew     = 2'($urandom);
    cfg_widening = 2'($urandom);
    k = 0;
    guard = 0;
    mid_start = 1'b0;
    while (k < vl && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = d_arr[k];
      in_mask  = m_arr[k];
      start    = (k == 1 && !mid_start);
      if (k == 1) mid_start = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (k < vl) check({tag, "_feed_timeout"}, k, vl);
    guard = 0;
    while (done_cnt == d0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    if (vl == 0) check({tag, "_done_lat"}, done_cyc - s_cyc, 1);
    else check({tag, "_done_lat"}, done_cyc - hs_cyc, 1);
    check({tag, "_n_writes"}, n_writes - w0, nw);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, {busy, in_ready, vrf_wr_en}, 3'b000);
  endtask

  task automatic fill_mask_ones();
    for (int i = 0; i < 256; i++) m_arr[i] = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, guard, vl, vsew, wid;
    n_reset = 1'b0;
    start = 1'b0;
    cfg_vd_addr = '0;
    cfg_vl = '0;
    cfg_vsew = 2'd0;
    cfg_widening = 2'd0;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_mask = 1'b1;
    vrf_wr_ready = 1'b1;
    fill_mask_ones();
    repeat (2) @(negedge clk);
    check("rst_outputs", {in_ready, vrf_wr_en, busy, done, vrf_wr_addr, vrf_wr_data, vrf_wr_be},
          '0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;

    // bytes, full words; upper in_data bits are garbage
    for (int i = 0; i < 8; i++) d_arr[i] = {24'($urandom), 8'(8'h11 * (i + 1))};
    run_op("t1_bytes", 'h10, 8, 0, 0, 0, 1'b0);

    // 8b widened x2 to halfwords, partial tail
    d_arr[0] = 32'hDEAD_AAAA;
    d_arr[1] = 32'hBEEF_BBBB;
    d_arr[2] = 32'h1234_CCCC;
    run_op("t2_widen", 'h20, 3, 0, 1, 1, 1'b0);

    // 32b elements with VRF stalls
    d_arr[0] = 32'hCAFE_0001;
    d_arr[1] = 32'hCAFE_0002;
    run_op("t3_stall", 'h30, 2, 2, 0, 2, 1'b0);

    // empty op
    run_op("t4_vl0", 'h40, 0, 1, 0, 0, 1'b0);

    // address wrap
    for (int i = 0; i < 8; i++) d_arr[i] = $urandom;
    run_op("t8_wrap", 511, 8, 0, 0, 1, 1'b1);

    // reset during a stalled write
    rdy_mode = 3;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_vd_addr = ADDR_W'('h55);
    cfg_vl = VL_W'(8);
    cfg_vsew = 2'd0;
    cfg_widening = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0000_00A5;
    guard = 0;
    while (!vrf_wr_en && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check("t5_reached_write", vrf_wr_en, 1'b1);
    n_reset = 1'b0;
    @(negedge clk);
    check("t5_rst_outputs", {vrf_wr_en, busy, done, in_ready, vrf_wr_addr, vrf_wr_data, vrf_wr_be},
          '0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    for (int i = 0; i < 4; i++) d_arr[i] = 32'h0000_0010 + i;
    run_op("t5_fresh", 'h70, 4, 0, 0, 0, 1'b0);

`ifdef PE_WB_MASK_EN
    d_arr[0] = 32'h0000_1111;
    d_arr[1] = 32'h0000_2222;
    m_arr[0] = 1'b1;
    m_arr[1] = 1'b0;
    run_op("t6_mask", 'h80, 2, 1, 0, 0, 1'b0);
    m_arr[0] = 1'b0;
    run_op("t6_allmask", 'h81, 1, 2, 0, 0, 1'b0);
    fill_mask_ones();
`endif

    // random mix
    for (int r = 0; r < 8; r++) begin
      vl = $urandom_range(1, 20);
      vsew = $urandom_range(0, 2);
      wid = $urandom_range(0, 3);
      for (int i = 0; i < vl; i++) begin
        d_arr[i] = $urandom;
`ifdef PE_WB_MASK_EN
        m_arr[i] = ($urandom_range(0, 3) != 0);
`endif
      end
      run_op("rnd", $urandom_range(0, 511), vl, vsew, wid, $urandom_range(0, 2), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
